// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU for multi-cycle and pipelined execute stages.
// Single-cycle logic, arithmetic and compare ops. Iterative shift-add multiply
// and restoring unsigned divide/remainder. The result is held in registers
// until the consumer accepts it.
//
// Optional build macro: SEQ_ALU_FAST_MUL_EN. When it is defined, MUL/MULHU use
// a combinational multiplier and finish in one cycle.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready = state is IDLE)
//   in_op, in_a, in_b   operation code and operands, sampled on acceptance
//   out_valid/out_ready result handshake
//   out_result          registered result
//   out_bcond           registered branch condition
//   busy                high whenever the state is not IDLE
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_bcond,
  output logic             busy
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bcond_q, bcond_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               sel_hi_q, sel_hi_d;

  logic [WIDTH-1:0]   sc_res_c;
  logic               sc_bcond_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic               is_mul_c;
  logic               is_div_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [DW-1:0]      mul_next_c;
  logic [WIDTH:0]     div_trial_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   div_diff_c;
  logic [DW-1:0]      div_next_c;

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [DW-1:0]      prod_c;
  assign prod_c   = DW'(in_a) * DW'(in_b);
  assign is_mul_c = 1'b0;
`else
  assign is_mul_c = (in_op == 5'd16) || (in_op == 5'd17);
`endif
  assign is_div_c = (in_op == 5'd18) || (in_op == 5'd19);
  assign shamt_c  = in_b[SHAMT_W-1:0];

  // Single-cycle datapath: legacy encodings and compares
  always_comb begin
    sc_res_c   = '0;
    sc_bcond_c = 1'b0;
    case (in_op)
      5'd0:  sc_res_c = in_a + in_b;
      5'd1:  sc_res_c = in_a - in_b;
      5'd2:  sc_res_c = in_a;
      5'd3:  sc_res_c = ~in_a;
      5'd4:  sc_res_c = in_a & in_b;
      5'd5:  sc_res_c = in_a | in_b;
      5'd6:  sc_res_c = ~(in_a & in_b);
      5'd7:  sc_res_c = ~(in_a | in_b);
      5'd8:  sc_res_c = in_a ^ in_b;
      5'd9:  sc_res_c = ~(in_a ^ in_b);
      5'd10: sc_res_c = in_a << shamt_c;
      5'd11: sc_res_c = in_a >> shamt_c;
      5'd12: sc_res_c = {in_a[WIDTH-2:0], 1'b0};
      5'd13: sc_res_c = {in_a[WIDTH-1], in_a[WIDTH-1:1]};
      5'd14: sc_res_c = WIDTH'(0) - in_a;
      5'd15: sc_res_c = '0;
`ifdef SEQ_ALU_FAST_MUL_EN
      5'd16: sc_res_c = prod_c[WIDTH-1:0];
      5'd17: sc_res_c = prod_c[DW-1:WIDTH];
`endif
      5'd20: sc_bcond_c = (in_a == in_b);
      5'd21: sc_bcond_c = (in_a != in_b);
      5'd22: sc_bcond_c = ($signed(in_a) <  $signed(in_b));
      5'd23: sc_bcond_c = ($signed(in_a) >= $signed(in_b));
      5'd24: sc_bcond_c = (in_a <  in_b);
      5'd25: sc_bcond_c = (in_a >= in_b);
      default: sc_res_c = '0;
    endcase
    // compare results are the zero-extended condition; no other op sets bcond
    if (sc_bcond_c) begin
      sc_res_c = WIDTH'(1);
    end
  end

  // Shift-add step: acc = {partial high, remaining multiplier bits}
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};
  end

  // Restoring divide step: acc = {remainder, dividend/quotient}.
  // A zero divisor makes every step succeed, giving all-ones quotient and
  // remainder equal to the dividend without special-casing.
  always_comb begin
    div_trial_c = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_c    = (div_trial_c >= {1'b0, opb_q});
    div_diff_c  = div_trial_c[WIDTH-1:0] - opb_q;
    div_next_c  = {(div_ge_c ? div_diff_c : div_trial_c[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge_c};
  end

  // Next-state and datapath register update
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    bcond_d  = bcond_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    sel_hi_d = sel_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mul_c) begin
            opa_d    = in_a;
            opb_d    = in_b;
            sel_hi_d = in_op[0];
            cnt_d    = '0;
            acc_d    = {WIDTH'(0), in_b};
            state_d  = ST_MUL;
          end else if (is_div_c) begin
            opa_d    = in_a;
            opb_d    = in_b;
            sel_hi_d = in_op[0];
            cnt_d    = '0;
            acc_d    = {WIDTH'(0), in_a};
            state_d  = ST_DIV;
          end else begin
            res_d   = sc_res_c;
            bcond_d = sc_bcond_c;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next_c;
        cnt_d = cnt_q + SHAMT_W'(1);
        // the final iteration writes the result directly
        if (cnt_q == CNT_LAST) begin
          res_d   = sel_hi_q ? mul_next_c[DW-1:WIDTH] : mul_next_c[WIDTH-1:0];
          bcond_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = div_next_c;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = sel_hi_q ? div_next_c[DW-1:WIDTH] : div_next_c[WIDTH-1:0];
          bcond_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      bcond_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      sel_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      bcond_q  <= bcond_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      sel_hi_q <= sel_hi_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_bcond  = bcond_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32) with a result scoreboard.
module tb_seq_alu;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_bcond;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_res_q[$];
  logic        exp_bc_q[$];
  int          exp_lat_q[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_bcond  (out_bcond),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for WIDTH=32
  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a;
      5'd3:  return ~a;
      5'd4:  return a & b;
      5'd5:  return a | b;
      5'd6:  return ~(a & b);
      5'd7:  return ~(a | b);
      5'd8:  return a ^ b;
      5'd9:  return ~(a ^ b);
      5'd10: return a << b[4:0];
      5'd11: return a >> b[4:0];
      5'd12: return a << 1;
      5'd13: return 32'($signed(a) >>> 1);
      5'd14: return 32'(0) - a;
      5'd16: return p[31:0];
      5'd17: return p[63:32];
      5'd18: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd19: return (b == 0) ? a : a % b;
      5'd20: return {31'b0, a == b};
      5'd21: return {31'b0, a != b};
      5'd22: return {31'b0, $signed(a) < $signed(b)};
      5'd23: return {31'b0, $signed(a) >= $signed(b)};
      5'd24: return {31'b0, a < b};
      5'd25: return {31'b0, a >= b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op);
`ifdef SEQ_ALU_FAST_MUL_EN
    if (op == 5'd18 || op == 5'd19) return 33;
`else
    if (op >= 5'd16 && op <= 5'd19) return 33;
`endif
    return 1;
  endfunction

  // Issue one request, then score the result when out_valid rises.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb);
    int g;
    int lat;
    exp_res_q.push_back(er);
    exp_bc_q.push_back(eb);
    exp_lat_q.push_back(model_lat(op));
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("result", 64'(out_result), 64'(exp_res_q.pop_front()));
    check("bcond", 64'(out_bcond), 64'(exp_bc_q.pop_front()));
    check("latency", 64'(lat), 64'(exp_lat_q.pop_front()));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check("idle_after_hs", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    end
  endtask

  task automatic run_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = model_res(op, a, b);
    run_op(op, a, b, r, (op >= 5'd20 && op <= 5'd25) ? r[0] : 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic stale;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 5'd0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_bcond", 64'(out_bcond), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    run_op(5'd0,  32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_op(5'd13, 32'h8000_0004, 32'h0, 32'hC000_0002, 1'b0);
    run_op(5'd10, 32'h1, 32'h25, 32'h20, 1'b0);
    run_op(5'd22, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);
    run_op(5'd24, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_op(5'd20, 32'h1234, 32'h1234, 32'h1, 1'b1);
    run_op(5'd16, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 1'b0);
    run_op(5'd17, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 1'b0);
    run_op(5'd18, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op(5'd19, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op(5'd18, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(5'd19, 32'd55, 32'd0, 32'd55, 1'b0);
    run_op(5'd14, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0);
    run_op(5'd27, 32'h5, 32'h5, 32'h0, 1'b0);

    // Every opcode with edge and random operands
    for (int op = 0; op < 32; op++) begin
      for (int k = 0; k < 3; k++) begin
        run_model(5'(op), pick_operand(), pick_operand());
      end
    end

    // Backpressure: result held while the consumer stalls
    out_ready = 1'b0;
    run_op(5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 5'd0;
    in_a     = 32'd1;
    in_b     = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(out_result), 64'hFFFF_FFFE);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("bp_no_accept", 64'(out_valid), 64'd0);

    // Reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 5'd18;
    in_a     = 32'd100;
    in_b     = 32'd7;
    check("div_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("div_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_result", 64'(out_result), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU, intended for the multi-cycle and pipelined CPU execute stages.
- Keeps the existing 16 logic/arithmetic encodings.
- Adds branch-compare encodings that drive bcond.
- Adds iterative multiply and unsigned divide/remainder.
- Operands are accepted on a valid/ready handshake. The result is held in an output register until the consumer accepts it.

Parameters:
WIDTH, 32, datapath width in bits (must be >= 4 and a power of two).
SHAMT_W, $clog2(WIDTH), number of operand-2 LSBs used as the shift amount.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_op  input  5  operation code
in_a  input  WIDTH  operand 1
in_b  input  WIDTH  operand 2
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  registered result
out_bcond  output  1  registered branch condition
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_valid=0, out_result=0, out_bcond=0, busy=0, all iteration counters and partial registers=0. Reset asserted mid-MUL/DIV abandons the operation with no output.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). A request is accepted when in_valid && in_ready. in_op/in_a/in_b are sampled only on acceptance.
- Single-cycle ops are 0-15 and 20-25.
  - Accept -> DONE on the next edge, with out_valid=1.
  - Latency is 1 cycle.
- Ops 0-15 use the legacy ALU encoding:
  - 0 add; 1 sub; 2 pass a; 3 not a; 4 and; 5 or; 6 nand; 7 nor; 8 xor; 9 xnor.
  - 10 shl a by b[SHAMT_W-1:0]; 11 logical shr a by b[SHAMT_W-1:0].
  - 12 shl a by 1; 13 arithmetic shr a by 1; 14 two's-complement negate a; 15 zero.
  - Add/sub wrap modulo 2^WIDTH; there is no overflow flag.
  - Shift amounts above WIDTH-1 cannot occur because only the low SHAMT_W bits of b are used.
  - out_bcond=0 for these ops.
- Ops 20-25 are compares: 20 EQ, 21 NE, 22 LT signed, 23 GE signed, 24 LTU, 25 GEU.
  - out_bcond = compare result.
  - out_result = zero-extended bcond.
- Ops 16-19 are iterative:
  - 16 MUL: low WIDTH bits of the unsigned product.
  - 17 MULHU: high WIDTH bits of the unsigned product.
  - 18 DIVU: unsigned quotient.
  - 19 REMU: unsigned remainder.
  - MUL/MULHU go IDLE->MUL; DIVU/REMU go IDLE->DIV.
  - Each runs exactly WIDTH iteration cycles (one shift-add or one restoring-subtract step per cycle), then moves to DONE.
  - Latency is WIDTH+1 cycles from acceptance to out_valid.
  - out_bcond=0.
- Divide by zero (b==0): DIVU result = all ones, REMU result = a. The full WIDTH cycles are still taken, so latency is constant.
- Undefined ops (26-31): single-cycle, result 0, bcond 0.
- DONE state:
  - out_valid=1; out_result and out_bcond are stable until the handshake.
  - If out_ready=1, go to IDLE on the next edge and drop out_valid.
  - A new request cannot be accepted in the same cycle as the result handshake; in_ready rises in the cycle after.
  - out_ready may be held high indefinitely. With out_ready tied high, the minimum issue interval is 2 cycles for single-cycle ops.
- in_valid while busy is ignored. The requester must hold it until in_ready.
- busy=1 in MUL, DIV and DONE.

Optional Feature:
Macro SEQ_ALU_FAST_MUL_EN.
- Defined: ops 16/17 use a combinational WIDTH x WIDTH multiplier. They go IDLE->DONE with 1-cycle latency, like the other single-cycle ops, and the MUL state is unreachable.
- Undefined: iterative shift-add behaviour as specified above.
- DIVU/REMU are iterative in both builds.

Test Plan:
- Reset mid-divide: WIDTH=32, accept DIVU a=100 b=7, assert reset_n=0 at cycle 10 -> out_valid=0, busy=0, out_result=0 immediately (asynchronously). After release, in_ready=1 and no stale result appears.
- Single-cycle ops, out_ready=1: op0 a=0xFFFFFFFF b=1 -> result 0 after 1 cycle. op13 a=0x80000004 -> 0xC0000002. op10 a=1 b=0x25 -> 0x20 (shift by 5).
- Compares: op22 a=0xFFFFFFFF b=1 -> bcond=1, result=1. op24 same operands -> bcond=0, result=0. op20 a=b=0x1234 -> bcond=1.
- Multiply: op16 and op17 with a=0xFFFFFFFF b=2 -> low 0xFFFFFFFE, high 0x00000001. out_valid at exactly cycle 33 after accept, or cycle 1 with SEQ_ALU_FAST_MUL_EN.
- Divide: op18 a=100 b=7 -> 14; op19 -> 2. op18 b=0 -> 0xFFFFFFFF; op19 a=55 b=0 -> 55. Latency is 33 cycles in every case.
- Backpressure: complete op1 a=5 b=7 with out_ready=0 for 10 cycles -> out_valid stays 1, result stays 0xFFFFFFFE, in_ready stays 0. A new in_valid during this window is not accepted. Raise out_ready -> in_ready=1 on the next cycle.
